// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: opcodes, operand/result types, stored instruction record.
// The optional INSTR_REG_SAT_EN build uses sat32() to clamp ADD/SUB/MULT results to signed 32-bit.
package instr_register_pkg;

  localparam int INSTR_DEPTH  = 32;
  localparam int INSTR_ADDR_W = $clog2(INSTR_DEPTH);

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  res;
  } instruction_t;

  function automatic result_t sat32(input result_t v);
    if (v > 64'sd2147483647) begin
      return 64'sd2147483647;
    end else if (v < -64'sd2147483648) begin
      return -64'sd2147483648;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational execute stage: opcode and operands -> 64-bit result plus divide-by-zero flag.
// With INSTR_REG_SAT_EN defined, ADD/SUB/MULT results are clamped to the signed 32-bit range.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  res,
  output logic     div_err
);

  result_t a_s;
  result_t b_s;
  result_t raw_s;

  // Operands are sign-extended first so MULT keeps the full product and DIV of -2^31/-1 cannot overflow.
  always_comb begin
    a_s     = result_t'(op_a);
    b_s     = result_t'(op_b);
    raw_s   = 64'sd0;
    div_err = 1'b0;
    case (opc)
      ZERO:  raw_s = 64'sd0;
      PASSA: raw_s = a_s;
      PASSB: raw_s = b_s;
      ADD:   raw_s = a_s + b_s;
      SUB:   raw_s = a_s - b_s;
      MULT:  raw_s = a_s * b_s;
      DIV: begin
        if (op_b == 32'sd0) begin
          raw_s   = 64'sd0;
          div_err = 1'b1;
        end else begin
          raw_s   = a_s / b_s;
        end
      end
      MOD: begin
        if (op_b == 32'sd0) begin
          raw_s   = 64'sd0;
          div_err = 1'b1;
        end else begin
          raw_s   = a_s % b_s;
        end
      end
      default: raw_s = 64'sd0;
    endcase
  end

  // Result shaping: saturating build clamps the arithmetic ops only.
  always_comb begin
`ifdef INSTR_REG_SAT_EN
    if ((opc == ADD) || (opc == SUB) || (opc == MULT)) begin
      res = sat32(raw_s);
    end else begin
      res = raw_s;
    end
`else
    res = raw_s;
`endif
  end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register responder: 2-stage write pipeline (capture, execute/commit) and registered read.
// Optional build macro INSTR_REG_SAT_EN (handled in instr_alu) saturates ADD/SUB/MULT results.
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter int DEPTH  = INSTR_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] write_pointer,
  input  opcode_t           opcode,
  input  operand_t          operand_a,
  input  operand_t          operand_b,
  input  logic [ADDR_W-1:0] read_pointer,
  output instruction_t      instruction_word,
  output logic              rd_valid,
  output logic              div_err,
  output logic [ADDR_W:0]   write_count
);

  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_ptr_q,   s1_ptr_d;
  opcode_t           s1_opc_q,   s1_opc_d;
  operand_t          s1_a_q,     s1_a_d;
  operand_t          s1_b_q,     s1_b_d;

  instruction_t      mem_q [DEPTH];
  instruction_t      mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  err_q,   err_d;
  logic [ADDR_W:0]   count_q, count_d;

  instruction_t      rd_word_q,  rd_word_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q,   rd_err_d;

  result_t           alu_res_s;
  logic              alu_err_s;
  instruction_t      commit_word_s;

  instr_alu u_alu (
    .opc     (s1_opc_q),
    .op_a    (s1_a_q),
    .op_b    (s1_b_q),
    .res     (alu_res_s),
    .div_err (alu_err_s)
  );

  // Stage 1 capture; payload holds when idle so it only toggles on real writes.
  always_comb begin
    s1_valid_d = load_en;
    if (load_en) begin
      s1_ptr_d = write_pointer;
      s1_opc_d = opcode;
      s1_a_d   = operand_a;
      s1_b_d   = operand_b;
    end else begin
      s1_ptr_d = s1_ptr_q;
      s1_opc_d = s1_opc_q;
      s1_a_d   = s1_a_q;
      s1_b_d   = s1_b_q;
    end
  end

  // Stage 2 commit, then read from the post-commit view so a same-edge write is forwarded.
  always_comb begin
    mem_d         = mem_q;
    valid_d       = valid_q;
    err_d         = err_q;
    count_d       = count_q;
    commit_word_s = '{opc: s1_opc_q, op_a: s1_a_q, op_b: s1_b_q, res: alu_res_s};
    if (s1_valid_q) begin
      mem_d[s1_ptr_q]   = commit_word_s;
      valid_d[s1_ptr_q] = 1'b1;
      err_d[s1_ptr_q]   = alu_err_s;
      if (count_q != COUNT_MAX) begin
        count_d = count_q + COUNT_ONE;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
    rd_word_d  = mem_d[read_pointer];
    rd_valid_d = valid_d[read_pointer];
    rd_err_d   = err_d[read_pointer];
  end

  // State registers; reset discards any in-flight stage-1 write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_ptr_q   <= '0;
      s1_opc_q   <= ZERO;
      s1_a_q     <= 32'sd0;
      s1_b_q     <= 32'sd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q    <= '0;
      err_q      <= '0;
      count_q    <= '0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ptr_q   <= s1_ptr_d;
      s1_opc_q   <= s1_opc_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q    <= valid_d;
      err_q      <= err_d;
      count_q    <= count_d;
      rd_word_q  <= rd_word_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign instruction_word = rd_word_q;
  assign rd_valid         = rd_valid_q;
  assign div_err          = rd_err_q;
  assign write_count      = count_q;

endmodule
